irq_priority_engine: RTL and testbench
======================================

Name: irq_priority_engine

Overview:
- Parametrised, clocked interrupt-priority engine; successor to the combinational 8-input resolver.
- Holds IRR and ISR internally and arbitrates N channels with a rotating lowest-priority pointer.
- Drives an int/ack handshake that returns the winning channel ID.
- Accepts EOI/rotate/priority commands from the control logic.
- Sits between the IR pin capture and the data-bus/vector logic.

Parameters:
- N, 8, number of interrupt channels; power of two, 2..32.
- IDW, $clog2(N), width of channel ID fields.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- irq  in  N  raw interrupt request lines.
- imr  in  N  mask register; 1 = channel masked.
- trig_level  in  1  1 = level-triggered, 0 = edge-triggered.
- aeoi  in  1  automatic-EOI mode.
- special_mask  in  1  special mask mode: masked ISR bits do not block lower priorities.
- ack  in  1  one-cycle interrupt acknowledge pulse.
- cmd_valid  in  1  command strobe.
- cmd_op  in  3  command opcode.
- cmd_level  in  IDW  channel operand for commands.
- int_out  out  1  interrupt request to CPU, registered.
- vec_valid  out  1  one-cycle pulse; vec_id/spurious valid.
- vec_id  out  IDW  acknowledged channel.
- spurious  out  1  ack arrived with no eligible winner.
- isr_out  out  N  current ISR.
- irr_out  out  N  current IRR.

Behaviour:
- Reset (synchronous, all state): IRR=0, ISR=0, irq_q=0, L=N-1 (IR0 highest priority), auto_rot=0, int_out=0, vec_valid=0, vec_id=0, spurious=0.

IRR capture:
- Level mode: IRR[i] <= irq[i] every cycle.
- Edge mode: IRR[i] set when irq[i]=1 and irq_q[i]=0. Cleared when irq[i]=0 or when channel i is acknowledged. Set beats ack-clear in the same cycle.

Priority ranking:
- rank(i) = (i - L - 1) mod N; rank 0 is highest. Comparisons use rank, never raw index.

Winner selection (combinational, from registered state):
- cand = IRR & ~imr.
- blocking ISR set = ISR, or ISR & ~imr when special_mask=1.
- W = lowest-rank cand bit whose rank is strictly lower than the lowest rank in the blocking set.
- eligible = W exists.
- int_out <= eligible each cycle, giving 1-cycle latency from IRR change.

Ack handling (cycle with ack=1):
- Eligible: ISR[W] set unless aeoi=1; in edge mode IRR[W] cleared; vec_id <= W, spurious <= 0, vec_valid <= 1 next cycle.
- aeoi=1 and auto_rot=1: L <= W.
- Not eligible: vec_id <= N-1, spurious <= 1, vec_valid <= 1; ISR and IRR unchanged.

Commands (cycle with cmd_valid=1; H = lowest-rank set ISR bit):
- 0: no-op.
- 1: non-specific EOI, clear ISR[H].
- 2: specific EOI, clear ISR[cmd_level].
- 3: rotate on non-specific EOI, clear ISR[H], L <= H.
- 4: rotate on specific EOI, clear ISR[cmd_level], L <= cmd_level.
- 5: set priority, L <= cmd_level.
- 6: auto_rot <= 1.
- 7: auto_rot <= 0.
- Ops 1/3 with ISR=0: no effect.

Simultaneous events:
- Commands evaluate H on pre-cycle ISR.
- Ack set and command clear on the same bit: set wins.
- Command L update beats AEOI rotation.
- Ack and command both use the pre-cycle L.

Mid-operation reset:
- Drops int_out, clears ISR and IRR, and aborts any pending vec_valid.

Width rules:
- All index arithmetic is modulo N in IDW bits.
- cmd_level is always in range because N is a power of two.

Test Plan:
- Fixed priority, level mode, irq=0x24, ack → vec_id=2, ISR=0x04; int_out stays 1 only for IR5 after EOI op1, then ack → vec_id=5.
- Nesting: ISR=0x10, irq=0x20 → int_out=0; irq=0x08 → int_out=1, ack → vec_id=3, ISR=0x18; op1 clears bit 3 only.
- Rotation: op5 level=4, irq=0x21 → ack gives vec_id=5; op4 level=5 → L=5, subsequent irq=0xFF ack → vec_id=6.
- AEOI with auto_rot (op6), edge mode, pulse IR1 then IR1 again → each ack returns 1, ISR stays 0x00, L=1 after first ack.
- Edge request withdrawn: IR3 rises, falls before ack → IRR=0; ack → spurious=1, vec_id=N-1, ISR unchanged.
- Special mask: ISR=0x02, imr=0x02, special_mask=1, irq=0x80 → int_out=1; with special_mask=0 → int_out=0. Reset asserted mid-ack → all outputs 0 next cycle.

Source files
------------

// File: rtl/irq_priority_engine.sv
// Clocked interrupt-priority engine: IRR/ISR bookkeeping, rotating-priority
// arbitration over N channels, int/ack vector handshake and EOI/rotate commands.
module irq_priority_engine #(
  parameter int N   = 8,
  parameter int IDW = $clog2(N)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   irq,
  input  logic [N-1:0]   imr,
  input  logic           trig_level,
  input  logic           aeoi,
  input  logic           special_mask,
  input  logic           ack,
  input  logic           cmd_valid,
  input  logic [2:0]     cmd_op,
  input  logic [IDW-1:0] cmd_level,
  output logic           int_out,
  output logic           vec_valid,
  output logic [IDW-1:0] vec_id,
  output logic           spurious,
  output logic [N-1:0]   isr_out,
  output logic [N-1:0]   irr_out
);

  logic [N-1:0]   irr;
  logic [N-1:0]   isr;
  logic [N-1:0]   irq_q;
  logic [IDW-1:0] lpri;
  logic           auto_rot;

  logic [N-1:0]   cand;
  logic [N-1:0]   blk_set;
  logic           win_found;
  logic [IDW-1:0] win_id;
  logic [IDW-1:0] win_rank;
  logic           blk_found;
  logic [IDW-1:0] blk_rank;
  logic           h_found;
  logic [IDW-1:0] h_id;
  logic [IDW-1:0] idx;
  logic           eligible;

  logic [N-1:0]   isr_set;
  logic [N-1:0]   isr_clr;
  logic [N-1:0]   irr_ack_clr;
  logic [N-1:0]   isr_next;
  logic [N-1:0]   irr_next;
  logic [IDW-1:0] lpri_next;
  logic           auto_rot_next;

  assign cand    = irr & ~imr;
  assign blk_set = special_mask ? (isr & ~imr) : isr;

  // Walk channels in rank order, starting just above the lowest-priority pointer.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    win_rank  = '0;
    blk_found = 1'b0;
    blk_rank  = '0;
    h_found   = 1'b0;
    h_id      = '0;
    idx       = '0;
    for (int r = 0; r < N; r++) begin
      idx = lpri + IDW'(r + 1);
      if (!win_found && cand[idx]) begin
        win_found = 1'b1;
        win_id    = idx;
        win_rank  = IDW'(r);
      end
      if (!blk_found && blk_set[idx]) begin
        blk_found = 1'b1;
        blk_rank  = IDW'(r);
      end
      if (!h_found && isr[idx]) begin
        h_found = 1'b1;
        h_id    = idx;
      end
    end
    eligible = win_found && (!blk_found || (win_rank < blk_rank));
  end

  // Ack sets and command clears are merged so that a set on the same bit wins,
  // and command pointer updates override the AEOI auto-rotation.
  always_comb begin
    isr_set       = '0;
    isr_clr       = '0;
    irr_ack_clr   = '0;
    lpri_next     = lpri;
    auto_rot_next = auto_rot;
    if (ack && eligible) begin
      if (!aeoi)
        isr_set[win_id] = 1'b1;
      if (!trig_level)
        irr_ack_clr[win_id] = 1'b1;
      if (aeoi && auto_rot)
        lpri_next = win_id;
    end
    if (cmd_valid) begin
      case (cmd_op)
        3'd1: begin
          if (h_found)
            isr_clr[h_id] = 1'b1;
        end
        3'd2: isr_clr[cmd_level] = 1'b1;
        3'd3: begin
          if (h_found) begin
            isr_clr[h_id] = 1'b1;
            lpri_next     = h_id;
          end
        end
        3'd4: begin
          isr_clr[cmd_level] = 1'b1;
          lpri_next          = cmd_level;
        end
        3'd5: lpri_next = cmd_level;
        3'd6: auto_rot_next = 1'b1;
        3'd7: auto_rot_next = 1'b0;
        default: ;
      endcase
    end
    isr_next = (isr & ~isr_clr) | isr_set;
    if (trig_level)
      irr_next = irq;
    else
      irr_next = (irq & ~irq_q) | (irr & irq & ~irr_ack_clr);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      irr       <= '0;
      isr       <= '0;
      irq_q     <= '0;
      lpri      <= IDW'(N - 1);
      auto_rot  <= 1'b0;
      int_out   <= 1'b0;
      vec_valid <= 1'b0;
      vec_id    <= '0;
      spurious  <= 1'b0;
    end else begin
      irr       <= irr_next;
      isr       <= isr_next;
      irq_q     <= irq;
      lpri      <= lpri_next;
      auto_rot  <= auto_rot_next;
      int_out   <= eligible;
      vec_valid <= ack;
      if (ack) begin
        if (eligible) begin
          vec_id   <= win_id;
          spurious <= 1'b0;
        end else begin
          vec_id   <= IDW'(N - 1);
          spurious <= 1'b1;
        end
      end
    end
  end

  assign isr_out = isr;
  assign irr_out = irr;

endmodule

// File: tb/tb_irq_priority_engine.sv
// Scenario bench for irq_priority_engine: acks push expected vectors to a
// scoreboard queue that a monitor drains whenever vec_valid pulses.
module tb_irq_priority_engine;

  localparam int N   = 8;
  localparam int IDW = 3;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [N-1:0]   irq = '0;
  logic [N-1:0]   imr = '0;
  logic           trig_level = 1'b1;
  logic           aeoi = 1'b0;
  logic           special_mask = 1'b0;
  logic           ack = 1'b0;
  logic           cmd_valid = 1'b0;
  logic [2:0]     cmd_op = '0;
  logic [IDW-1:0] cmd_level = '0;
  logic           int_out;
  logic           vec_valid;
  logic [IDW-1:0] vec_id;
  logic           spurious;
  logic [N-1:0]   isr_out;
  logic [N-1:0]   irr_out;

  int checks = 0;
  int failures = 0;
  logic [IDW:0] exp_q[$];
  logic [IDW:0] exp_v;

  irq_priority_engine #(.N(N), .IDW(IDW)) dut (
    .clk(clk), .reset(reset), .irq(irq), .imr(imr), .trig_level(trig_level),
    .aeoi(aeoi), .special_mask(special_mask), .ack(ack), .cmd_valid(cmd_valid),
    .cmd_op(cmd_op), .cmd_level(cmd_level), .int_out(int_out),
    .vec_valid(vec_valid), .vec_id(vec_id), .spurious(spurious),
    .isr_out(isr_out), .irr_out(irr_out)
  );

  always #5 clk = ~clk;

  // Scoreboard consumer: each vec_valid pulse must match the oldest pushed ack.
  always @(negedge clk) begin
    if (vec_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("[TB] FAIL unexpected_vector: got id=%0d spur=%0b, required none", vec_id, spurious);
      end else begin
        exp_v = exp_q.pop_front();
        if ({spurious, vec_id} !== exp_v) begin
          failures++;
          $display("[TB] FAIL vector: got id=%0d spur=%0b, required id=%0d spur=%0b",
                   vec_id, spurious, exp_v[IDW-1:0], exp_v[IDW]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_ack(input int id, input bit spur);
    ack = 1'b1;
    exp_q.push_back({spur, IDW'(id)});
    tick();
    ack = 1'b0;
  endtask

  task automatic do_cmd(input int op, input int lvl);
    cmd_valid = 1'b1;
    cmd_op    = 3'(op);
    cmd_level = IDW'(lvl);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; irq = '1; trig_level = 1'b1;
    tick(); tick();
    checks++; if (int_out !== 1'b0)   begin failures++; $display("[TB] FAIL reset_int: got %b required 0", int_out); end
    checks++; if (vec_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_vv: got %b required 0", vec_valid); end
    checks++; if (vec_id !== 3'd0)    begin failures++; $display("[TB] FAIL reset_id: got %0d required 0", vec_id); end
    checks++; if (spurious !== 1'b0)  begin failures++; $display("[TB] FAIL reset_spur: got %b required 0", spurious); end
    checks++; if (isr_out !== 8'h00)  begin failures++; $display("[TB] FAIL reset_isr: got %h required 00", isr_out); end
    checks++; if (irr_out !== 8'h00)  begin failures++; $display("[TB] FAIL reset_irr: got %h required 00", irr_out); end
    reset = 1'b0; irq = '0;
    tick();
  endtask

  task automatic test_fixed_priority();
    trig_level = 1'b1; irq = 8'h24;
    tick();
    checks++; if (irr_out !== 8'h24) begin failures++; $display("[TB] FAIL fixed_irr: got %h required 24", irr_out); end
    tick();
    checks++; if (int_out !== 1'b1)  begin failures++; $display("[TB] FAIL fixed_int: got %b required 1", int_out); end
    do_ack(2, 1'b0);
    checks++; if (isr_out !== 8'h04) begin failures++; $display("[TB] FAIL fixed_isr: got %h required 04", isr_out); end
    tick();
    checks++; if (int_out !== 1'b0)  begin failures++; $display("[TB] FAIL fixed_blocked: got %b required 0", int_out); end
    irq = 8'h20;
    do_cmd(1, 0);
    tick();
    checks++; if (int_out !== 1'b1)  begin failures++; $display("[TB] FAIL fixed_ir5_int: got %b required 1", int_out); end
    do_ack(5, 1'b0);
    checks++; if (isr_out !== 8'h20) begin failures++; $display("[TB] FAIL fixed_isr5: got %h required 20", isr_out); end
    irq = 8'h00;
    do_cmd(1, 0);
    checks++; if (isr_out !== 8'h00) begin failures++; $display("[TB] FAIL fixed_eoi: got %h required 00", isr_out); end
  endtask

  task automatic test_nesting();
    irq = 8'h10;
    tick(); tick();
    do_ack(4, 1'b0);
    checks++; if (isr_out !== 8'h10) begin failures++; $display("[TB] FAIL nest_isr4: got %h required 10", isr_out); end
    irq = 8'h20;
    tick(); tick();
    checks++; if (int_out !== 1'b0)  begin failures++; $display("[TB] FAIL nest_lower_blocked: got %b required 0", int_out); end
    irq = 8'h08;
    tick(); tick();
    checks++; if (int_out !== 1'b1)  begin failures++; $display("[TB] FAIL nest_higher_int: got %b required 1", int_out); end
    do_ack(3, 1'b0);
    checks++; if (isr_out !== 8'h18) begin failures++; $display("[TB] FAIL nest_isr: got %h required 18", isr_out); end
    do_cmd(1, 0);
    checks++; if (isr_out !== 8'h10) begin failures++; $display("[TB] FAIL nest_eoi: got %h required 10", isr_out); end
    irq = 8'h00;
    do_cmd(1, 0);
    checks++; if (isr_out !== 8'h00) begin failures++; $display("[TB] FAIL nest_eoi2: got %h required 00", isr_out); end
  endtask

  task automatic test_rotation();
    do_cmd(5, 4);
    irq = 8'h21;
    tick(); tick();
    do_ack(5, 1'b0);
    checks++; if (isr_out !== 8'h20) begin failures++; $display("[TB] FAIL rot_isr5: got %h required 20", isr_out); end
    do_cmd(4, 5);
    checks++; if (isr_out !== 8'h00) begin failures++; $display("[TB] FAIL rot_seoi: got %h required 00", isr_out); end
    irq = 8'hFF;
    tick();
    do_ack(6, 1'b0);
    checks++; if (isr_out !== 8'h40) begin failures++; $display("[TB] FAIL rot_isr6: got %h required 40", isr_out); end
    irq = 8'h00;
    do_cmd(2, 6);
    do_cmd(5, 7);
    checks++; if (isr_out !== 8'h00) begin failures++; $display("[TB] FAIL rot_clean: got %h required 00", isr_out); end
  endtask

  task automatic test_aeoi_rotation();
    trig_level = 1'b0; aeoi = 1'b1; irq = 8'h00;
    do_cmd(6, 0);
    irq = 8'h02;
    tick();
    checks++; if (irr_out !== 8'h02) begin failures++; $display("[TB] FAIL aeoi_irr: got %h required 02", irr_out); end
    do_ack(1, 1'b0);
    checks++; if (isr_out !== 8'h00) begin failures++; $display("[TB] FAIL aeoi_isr: got %h required 00", isr_out); end
    checks++; if (irr_out !== 8'h00) begin failures++; $display("[TB] FAIL aeoi_irr_clr: got %h required 00", irr_out); end
    irq = 8'h00;
    tick();
    irq = 8'h06;
    tick();
    checks++; if (irr_out !== 8'h06) begin failures++; $display("[TB] FAIL aeoi_irr2: got %h required 06", irr_out); end
    do_ack(2, 1'b0);
    do_ack(1, 1'b0);
    checks++; if (isr_out !== 8'h00) begin failures++; $display("[TB] FAIL aeoi_isr2: got %h required 00", isr_out); end
    checks++; if (irr_out !== 8'h00) begin failures++; $display("[TB] FAIL aeoi_irr_end: got %h required 00", irr_out); end
    irq = 8'h00;
    do_cmd(7, 0);
    aeoi = 1'b0;
    do_cmd(5, 7);
  endtask

  task automatic test_edge_withdrawn();
    trig_level = 1'b0;
    irq = 8'h08;
    tick();
    checks++; if (irr_out !== 8'h08) begin failures++; $display("[TB] FAIL wd_irr_set: got %h required 08", irr_out); end
    irq = 8'h00;
    tick();
    checks++; if (irr_out !== 8'h00) begin failures++; $display("[TB] FAIL wd_irr_clr: got %h required 00", irr_out); end
    do_ack(N - 1, 1'b1);
    checks++; if (isr_out !== 8'h00) begin failures++; $display("[TB] FAIL wd_isr: got %h required 00", isr_out); end
  endtask

  task automatic test_back_to_back();
    trig_level = 1'b1; irq = 8'h10;
    tick();
    do_ack(4, 1'b0);
    irq = 8'h18;
    tick();
    ack = 1'b1; cmd_valid = 1'b1; cmd_op = 3'd1; cmd_level = '0;
    exp_q.push_back({1'b0, 3'd3});
    tick();
    ack = 1'b0; cmd_valid = 1'b0;
    checks++; if (isr_out !== 8'h08) begin failures++; $display("[TB] FAIL b2b_ack_eoi: got %h required 08", isr_out); end
    irq = 8'h08;
    do_cmd(2, 3);
    checks++; if (isr_out !== 8'h00) begin failures++; $display("[TB] FAIL b2b_seoi: got %h required 00", isr_out); end
    ack = 1'b1; cmd_valid = 1'b1; cmd_op = 3'd2; cmd_level = 3'd3;
    exp_q.push_back({1'b0, 3'd3});
    tick();
    ack = 1'b0; cmd_valid = 1'b0;
    checks++; if (isr_out !== 8'h08) begin failures++; $display("[TB] FAIL b2b_set_wins: got %h required 08", isr_out); end
    irq = 8'h00;
    do_cmd(2, 3);
    checks++; if (isr_out !== 8'h00) begin failures++; $display("[TB] FAIL b2b_clean: got %h required 00", isr_out); end
  endtask

  task automatic test_special_mask();
    trig_level = 1'b1; imr = 8'h00; irq = 8'h02;
    tick();
    do_ack(1, 1'b0);
    checks++; if (isr_out !== 8'h02) begin failures++; $display("[TB] FAIL smm_isr: got %h required 02", isr_out); end
    irq = 8'h80; imr = 8'h02; special_mask = 1'b1;
    tick(); tick();
    checks++; if (int_out !== 1'b1)  begin failures++; $display("[TB] FAIL smm_on_int: got %b required 1", int_out); end
    special_mask = 1'b0;
    tick(); tick();
    checks++; if (int_out !== 1'b0)  begin failures++; $display("[TB] FAIL smm_off_int: got %b required 0", int_out); end
    special_mask = 1'b1;
    tick();
    ack = 1'b1; reset = 1'b1;
    tick();
    ack = 1'b0;
    checks++; if (int_out !== 1'b0)   begin failures++; $display("[TB] FAIL midrst_int: got %b required 0", int_out); end
    checks++; if (vec_valid !== 1'b0) begin failures++; $display("[TB] FAIL midrst_vv: got %b required 0", vec_valid); end
    checks++; if (isr_out !== 8'h00)  begin failures++; $display("[TB] FAIL midrst_isr: got %h required 00", isr_out); end
    checks++; if (irr_out !== 8'h00)  begin failures++; $display("[TB] FAIL midrst_irr: got %h required 00", irr_out); end
    checks++; if (spurious !== 1'b0)  begin failures++; $display("[TB] FAIL midrst_spur: got %b required 0", spurious); end
    reset = 1'b0; irq = 8'h00; imr = 8'h00; special_mask = 1'b0;
    tick(); tick();
  endtask

  initial begin
    test_reset();
    test_fixed_priority();
    test_nesting();
    test_rotation();
    test_aeoi_rotation();
    test_edge_withdrawn();
    test_back_to_back();
    test_special_mask();
    tick();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
